// File: rtl/ncpu32k_fb_arbiter.sv
// Arbiter sharing the frontend memory bus between the icache (read-only) and dcache refill ports.
// One transaction in flight at a time; optional B-channel watchdog returns a bus-error response.
module ncpu32k_fb_arbiter #(
    parameter int CONFIG_FIXED_PRIO = 0,
    parameter int CONFIG_TIMEOUT    = 0,
    parameter int AW                = 32,
    parameter int IW                = 32,
    parameter int DW                = 32
) (
    input  logic          clk,
    input  logic          rst,
    // icache port
    input  logic          ibus_AVALID,
    output logic          ibus_AREADY,
    input  logic [AW-1:0] ibus_AADDR,
    input  logic [1:0]    ibus_AEXC,
    output logic          ibus_BVALID,
    input  logic          ibus_BREADY,
    output logic [IW-1:0] ibus_BDATA,
    output logic [1:0]    ibus_BEXC,
    // dcache port
    input  logic          dbus_AVALID,
    output logic          dbus_AREADY,
    input  logic [AW-1:0] dbus_AADDR,
    input  logic [1:0]    dbus_AEXC,
    input  logic [3:0]    dbus_AWMSK,
    input  logic [DW-1:0] dbus_ADATA,
    output logic          dbus_BVALID,
    input  logic          dbus_BREADY,
    output logic [DW-1:0] dbus_BDATA,
    output logic [1:0]    dbus_BEXC,
    // shared bus
    output logic          fb_mbus_AVALID,
    input  logic          fb_mbus_AREADY,
    output logic [AW-1:0] fb_mbus_AADDR,
    output logic [1:0]    fb_mbus_AEXC,
    output logic [3:0]    fb_mbus_AWMSK,
    output logic [DW-1:0] fb_mbus_ADATA,
    input  logic          fb_mbus_BVALID,
    output logic          fb_mbus_BREADY,
    input  logic [DW-1:0] fb_mbus_BDATA,
    input  logic [1:0]    fb_mbus_BEXC
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    localparam bit          FIXED_PRIO = (CONFIG_FIXED_PRIO != 0);
    localparam bit          WDOG_EN    = (CONFIG_TIMEOUT != 0);
    localparam logic [15:0] WDOG_LIMIT = CONFIG_TIMEOUT[15:0];

    state_t        state, state_nxt;
    logic          owner, owner_nxt;      // 1 = dbus, 0 = ibus
    logic          rr_ptr, rr_ptr_nxt;    // side that wins the next tie
    logic [15:0]   wdog, wdog_nxt;

    logic          owner_avalid;
    logic          owner_bready;
    logic          timed_out;
    logic          b_valid;
    logic [DW-1:0] b_data;
    logic [1:0]    b_exc;

    // A fields follow the owner; ibus is read-only so write mask/data are forced to zero
    assign fb_mbus_AADDR = owner ? dbus_AADDR : ibus_AADDR;
    assign fb_mbus_AEXC  = owner ? dbus_AEXC  : ibus_AEXC;
    assign fb_mbus_AWMSK = owner ? dbus_AWMSK : '0;
    assign fb_mbus_ADATA = owner ? dbus_ADATA : '0;

    assign owner_avalid = owner ? dbus_AVALID : ibus_AVALID;
    assign owner_bready = owner ? dbus_BREADY : ibus_BREADY;
    assign timed_out    = WDOG_EN && (wdog == WDOG_LIMIT);

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        rr_ptr_nxt     = rr_ptr;
        wdog_nxt       = wdog;
        fb_mbus_AVALID = 1'b0;
        fb_mbus_BREADY = 1'b0;
        ibus_AREADY    = 1'b0;
        dbus_AREADY    = 1'b0;
        b_valid        = 1'b0;
        b_data         = '0;
        b_exc          = 2'b00;

        case (state)
            S_IDLE: begin
                // Sink any late response left over from a timeout or reset
                fb_mbus_BREADY = 1'b1;
                if (ibus_AVALID || dbus_AVALID) begin
                    owner_nxt = dbus_AVALID && (!ibus_AVALID || FIXED_PRIO || rr_ptr);
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                fb_mbus_AVALID = owner_avalid;
                if (owner) dbus_AREADY = fb_mbus_AREADY;
                else       ibus_AREADY = fb_mbus_AREADY;
                if (!owner_avalid) begin
                    state_nxt = S_IDLE;
                end else if (fb_mbus_AREADY) begin
                    state_nxt = S_RESP;
                    wdog_nxt  = '0;
                end
            end
            S_RESP: begin
                // A real response takes precedence over a same-cycle timeout
                if (fb_mbus_BVALID) begin
                    b_valid        = 1'b1;
                    b_data         = fb_mbus_BDATA;
                    b_exc          = fb_mbus_BEXC;
                    fb_mbus_BREADY = owner_bready;
                    if (owner_bready) begin
                        state_nxt  = S_IDLE;
                        rr_ptr_nxt = ~owner;
                    end
                end else if (timed_out) begin
                    b_valid = 1'b1;
                    b_exc   = 2'b11;
                    if (owner_bready) begin
                        state_nxt  = S_IDLE;
                        rr_ptr_nxt = ~owner;
                    end
                end else if (WDOG_EN) begin
                    wdog_nxt = wdog + 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ibus_BVALID = b_valid & ~owner;
    assign dbus_BVALID = b_valid & owner;
    assign ibus_BDATA  = b_data[IW-1:0];
    assign dbus_BDATA  = b_data;
    assign ibus_BEXC   = b_exc;
    assign dbus_BEXC   = b_exc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
            wdog   <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            wdog   <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_ncpu32k_fb_arbiter.sv
// Directed bench for ncpu32k_fb_arbiter: a round-robin/timeout instance and a fixed-priority
// instance share the same stimulus; each task checks its own scenario.
module tb_ncpu32k_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_AVALID, ibus_BREADY;
    logic [31:0] ibus_AADDR;
    logic [1:0]  ibus_AEXC;
    logic        dbus_AVALID, dbus_BREADY;
    logic [31:0] dbus_AADDR, dbus_ADATA;
    logic [1:0]  dbus_AEXC;
    logic [3:0]  dbus_AWMSK;
    logic        fb_mbus_AREADY, fb_mbus_BVALID;
    logic [31:0] fb_mbus_BDATA;
    logic [1:0]  fb_mbus_BEXC;

    // round-robin, timeout 8
    logic        ibus_AREADY, ibus_BVALID, dbus_AREADY, dbus_BVALID;
    logic [31:0] ibus_BDATA, dbus_BDATA;
    logic [1:0]  ibus_BEXC, dbus_BEXC;
    logic        fb_mbus_AVALID, fb_mbus_BREADY;
    logic [31:0] fb_mbus_AADDR, fb_mbus_ADATA;
    logic [1:0]  fb_mbus_AEXC;
    logic [3:0]  fb_mbus_AWMSK;

    // fixed priority, no watchdog
    logic        ibus_AREADY_f, ibus_BVALID_f, dbus_AREADY_f, dbus_BVALID_f;
    logic [31:0] ibus_BDATA_f, dbus_BDATA_f;
    logic [1:0]  ibus_BEXC_f, dbus_BEXC_f;
    logic        fb_mbus_AVALID_f, fb_mbus_BREADY_f;
    logic [31:0] fb_mbus_AADDR_f, fb_mbus_ADATA_f;
    logic [1:0]  fb_mbus_AEXC_f;
    logic [3:0]  fb_mbus_AWMSK_f;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ncpu32k_fb_arbiter #(
        .CONFIG_FIXED_PRIO(0), .CONFIG_TIMEOUT(8), .AW(32), .IW(32), .DW(32)
    ) dut (
        .clk(clk), .rst(rst),
        .ibus_AVALID(ibus_AVALID), .ibus_AREADY(ibus_AREADY), .ibus_AADDR(ibus_AADDR),
        .ibus_AEXC(ibus_AEXC), .ibus_BVALID(ibus_BVALID), .ibus_BREADY(ibus_BREADY),
        .ibus_BDATA(ibus_BDATA), .ibus_BEXC(ibus_BEXC),
        .dbus_AVALID(dbus_AVALID), .dbus_AREADY(dbus_AREADY), .dbus_AADDR(dbus_AADDR),
        .dbus_AEXC(dbus_AEXC), .dbus_AWMSK(dbus_AWMSK), .dbus_ADATA(dbus_ADATA),
        .dbus_BVALID(dbus_BVALID), .dbus_BREADY(dbus_BREADY), .dbus_BDATA(dbus_BDATA),
        .dbus_BEXC(dbus_BEXC),
        .fb_mbus_AVALID(fb_mbus_AVALID), .fb_mbus_AREADY(fb_mbus_AREADY),
        .fb_mbus_AADDR(fb_mbus_AADDR), .fb_mbus_AEXC(fb_mbus_AEXC),
        .fb_mbus_AWMSK(fb_mbus_AWMSK), .fb_mbus_ADATA(fb_mbus_ADATA),
        .fb_mbus_BVALID(fb_mbus_BVALID), .fb_mbus_BREADY(fb_mbus_BREADY),
        .fb_mbus_BDATA(fb_mbus_BDATA), .fb_mbus_BEXC(fb_mbus_BEXC)
    );

    ncpu32k_fb_arbiter #(
        .CONFIG_FIXED_PRIO(1), .CONFIG_TIMEOUT(0), .AW(32), .IW(32), .DW(32)
    ) dut_f (
        .clk(clk), .rst(rst),
        .ibus_AVALID(ibus_AVALID), .ibus_AREADY(ibus_AREADY_f), .ibus_AADDR(ibus_AADDR),
        .ibus_AEXC(ibus_AEXC), .ibus_BVALID(ibus_BVALID_f), .ibus_BREADY(ibus_BREADY),
        .ibus_BDATA(ibus_BDATA_f), .ibus_BEXC(ibus_BEXC_f),
        .dbus_AVALID(dbus_AVALID), .dbus_AREADY(dbus_AREADY_f), .dbus_AADDR(dbus_AADDR),
        .dbus_AEXC(dbus_AEXC), .dbus_AWMSK(dbus_AWMSK), .dbus_ADATA(dbus_ADATA),
        .dbus_BVALID(dbus_BVALID_f), .dbus_BREADY(dbus_BREADY), .dbus_BDATA(dbus_BDATA_f),
        .dbus_BEXC(dbus_BEXC_f),
        .fb_mbus_AVALID(fb_mbus_AVALID_f), .fb_mbus_AREADY(fb_mbus_AREADY),
        .fb_mbus_AADDR(fb_mbus_AADDR_f), .fb_mbus_AEXC(fb_mbus_AEXC_f),
        .fb_mbus_AWMSK(fb_mbus_AWMSK_f), .fb_mbus_ADATA(fb_mbus_ADATA_f),
        .fb_mbus_BVALID(fb_mbus_BVALID), .fb_mbus_BREADY(fb_mbus_BREADY_f),
        .fb_mbus_BDATA(fb_mbus_BDATA), .fb_mbus_BEXC(fb_mbus_BEXC)
    );

    // inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ibus_AVALID = 1'b0; ibus_AADDR = '0; ibus_AEXC = 2'b00; ibus_BREADY = 1'b0;
        dbus_AVALID = 1'b0; dbus_AADDR = '0; dbus_AEXC = 2'b00; dbus_AWMSK = '0;
        dbus_ADATA = '0; dbus_BREADY = 1'b0;
        fb_mbus_AREADY = 1'b0; fb_mbus_BVALID = 1'b0; fb_mbus_BDATA = '0; fb_mbus_BEXC = 2'b00;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #2;
        checks++;
        if ({fb_mbus_AVALID, fb_mbus_BREADY, ibus_AREADY, dbus_AREADY, ibus_BVALID, dbus_BVALID}
            !== 6'b010000) begin
            errs++;
            $display("FAIL reset_rr got=%b exp=010000", {fb_mbus_AVALID, fb_mbus_BREADY,
                     ibus_AREADY, dbus_AREADY, ibus_BVALID, dbus_BVALID});
        end
        checks++;
        if ({fb_mbus_AVALID_f, fb_mbus_BREADY_f, ibus_AREADY_f, dbus_AREADY_f, ibus_BVALID_f,
             dbus_BVALID_f} !== 6'b010000) begin
            errs++;
            $display("FAIL reset_fp got=%b exp=010000", {fb_mbus_AVALID_f, fb_mbus_BREADY_f,
                     ibus_AREADY_f, dbus_AREADY_f, ibus_BVALID_f, dbus_BVALID_f});
        end
        nxt();
    endtask

    task automatic test_ibus_read;
        bit dbv_seen = 1'b0;
        idle_inputs();
        ibus_AVALID = 1'b1; ibus_AADDR = 32'h100; ibus_BREADY = 1'b1;
        dbus_AWMSK = 4'hF; dbus_ADATA = 32'hAAAA5555;  // must not leak onto the bus
        fb_mbus_AREADY = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) ibus_AVALID = 1'b0;
            if (c == 3) begin fb_mbus_BVALID = 1'b1; fb_mbus_BDATA = 32'hDEADBEEF; end
            if (c == 4) fb_mbus_BVALID = 1'b0;
            #2;
            if (dbus_BVALID) dbv_seen = 1'b1;
            if (c == 0) begin
                checks++;
                if ({fb_mbus_AVALID, ibus_AREADY} !== 2'b00) begin
                    errs++;
                    $display("FAIL rd_grant_latency got=%b exp=00", {fb_mbus_AVALID, ibus_AREADY});
                end
            end
            if (c == 1) begin
                checks++;
                if ({fb_mbus_AVALID, fb_mbus_AADDR, fb_mbus_AWMSK, fb_mbus_ADATA, ibus_AREADY,
                     dbus_AREADY} !== {1'b1, 32'h100, 4'h0, 32'h0, 1'b1, 1'b0}) begin
                    errs++;
                    $display("FAIL rd_req got=%b/%h/%h/%h/%b/%b exp=1/00000100/0/00000000/1/0",
                             fb_mbus_AVALID, fb_mbus_AADDR, fb_mbus_AWMSK, fb_mbus_ADATA,
                             ibus_AREADY, dbus_AREADY);
                end
            end
            if (c == 2) begin
                checks++;
                if ({ibus_BVALID, ibus_AREADY, fb_mbus_AVALID} !== 3'b000) begin
                    errs++;
                    $display("FAIL rd_wait got=%b exp=000", {ibus_BVALID, ibus_AREADY, fb_mbus_AVALID});
                end
            end
            if (c == 3) begin
                checks++;
                if ({ibus_BVALID, ibus_BDATA, ibus_BEXC, fb_mbus_BREADY}
                    !== {1'b1, 32'hDEADBEEF, 2'b00, 1'b1}) begin
                    errs++;
                    $display("FAIL rd_resp got=%b/%h/%b/%b exp=1/deadbeef/00/1",
                             ibus_BVALID, ibus_BDATA, ibus_BEXC, fb_mbus_BREADY);
                end
            end
            if (c == 4) begin
                checks++;
                if ({ibus_BVALID, fb_mbus_BREADY} !== 2'b01) begin
                    errs++;
                    $display("FAIL rd_back_idle got=%b exp=01", {ibus_BVALID, fb_mbus_BREADY});
                end
            end
            nxt();
        end
        checks++;
        if (dbv_seen !== 1'b0) begin
            errs++;
            $display("FAIL rd_dbus_bvalid got=%b exp=0", dbv_seen);
        end
    endtask

    // both masters request every cycle against a zero-wait slave
    task automatic test_back_to_back;
        int g_rr[6];
        int g_fp[6];
        int n_rr = 0;
        int n_fp = 0;
        bit ibus_ar_fp = 1'b0;
        bit addr_bad = 1'b0;
        do_reset();
        ibus_AVALID = 1'b1; ibus_AADDR = 32'h200; ibus_BREADY = 1'b1;
        dbus_AVALID = 1'b1; dbus_AADDR = 32'h300; dbus_BREADY = 1'b1;
        fb_mbus_AREADY = 1'b1; fb_mbus_BVALID = 1'b1; fb_mbus_BDATA = 32'h5A5A5A5A;
        for (int c = 0; c < 18; c++) begin
            #2;
            if (ibus_AREADY_f) ibus_ar_fp = 1'b1;
            if (fb_mbus_AVALID && fb_mbus_AREADY && n_rr < 6) begin
                g_rr[n_rr] = dbus_AREADY ? 1 : (ibus_AREADY ? 0 : 9);
                if (fb_mbus_AADDR !== (dbus_AREADY ? 32'h300 : 32'h200)) addr_bad = 1'b1;
                n_rr++;
            end
            if (fb_mbus_AVALID_f && fb_mbus_AREADY && n_fp < 6) begin
                g_fp[n_fp] = dbus_AREADY_f ? 1 : (ibus_AREADY_f ? 0 : 9);
                n_fp++;
            end
            nxt();
        end
        checks++;
        if (n_rr != 6) begin
            errs++;
            $display("FAIL b2b_rr_count got=%0d exp=6", n_rr);
        end
        checks++;
        if (n_fp != 6) begin
            errs++;
            $display("FAIL b2b_fp_count got=%0d exp=6", n_fp);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i < n_rr && g_rr[i] != (i % 2)) begin
                errs++;
                $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, g_rr[i], i % 2);
            end
            checks++;
            if (i < n_fp && g_fp[i] != 1) begin
                errs++;
                $display("FAIL fp_grant[%0d] got=%0d exp=1", i, g_fp[i]);
            end
        end
        checks++;
        if (ibus_ar_fp !== 1'b0) begin
            errs++;
            $display("FAIL fp_ibus_aready got=%b exp=0", ibus_ar_fp);
        end
        checks++;
        if (addr_bad !== 1'b0) begin
            errs++;
            $display("FAIL b2b_aaddr got=%b exp=0", addr_bad);
        end
        do_reset();
    endtask

    task automatic test_write_stall;
        int pulses = 0;
        int hs = 0;
        idle_inputs();
        dbus_AVALID = 1'b1; dbus_AADDR = 32'h400; dbus_AWMSK = 4'b0011;
        dbus_ADATA = 32'h12345678; dbus_BREADY = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) fb_mbus_AREADY = 1'b1;
            if (c == 7) dbus_AVALID = 1'b0;
            if (c == 8) begin fb_mbus_BVALID = 1'b1; fb_mbus_BDATA = 32'h0BADF00D; end
            if (c == 9) fb_mbus_BVALID = 1'b0;
            #2;
            if (dbus_AREADY) pulses++;
            if (fb_mbus_AVALID && fb_mbus_AREADY) hs++;
            if (c >= 1 && c <= 5) begin
                checks++;
                if ({fb_mbus_AVALID, fb_mbus_AADDR, fb_mbus_AWMSK, fb_mbus_ADATA, dbus_AREADY}
                    !== {1'b1, 32'h400, 4'b0011, 32'h12345678, 1'b0}) begin
                    errs++;
                    $display("FAIL wr_stall_c%0d got=%b/%h/%b/%h/%b exp=1/00000400/0011/12345678/0",
                             c, fb_mbus_AVALID, fb_mbus_AADDR, fb_mbus_AWMSK, fb_mbus_ADATA,
                             dbus_AREADY);
                end
            end
            if (c == 8) begin
                checks++;
                if ({dbus_BVALID, dbus_BDATA, fb_mbus_BREADY, ibus_BVALID}
                    !== {1'b1, 32'h0BADF00D, 1'b1, 1'b0}) begin
                    errs++;
                    $display("FAIL wr_resp got=%b/%h/%b/%b exp=1/0badf00d/1/0",
                             dbus_BVALID, dbus_BDATA, fb_mbus_BREADY, ibus_BVALID);
                end
            end
            nxt();
        end
        checks++;
        if (pulses != 1) begin
            errs++;
            $display("FAIL wr_aready_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if (hs != 1) begin
            errs++;
            $display("FAIL wr_a_handshakes got=%0d exp=1", hs);
        end
    endtask

    task automatic test_abort;
        idle_inputs();
        dbus_AVALID = 1'b1; dbus_AADDR = 32'h900;
        nxt();
        dbus_AVALID = 1'b0;
        #2;
        checks++;
        if ({fb_mbus_AVALID, dbus_AREADY} !== 2'b00) begin
            errs++;
            $display("FAIL abort_req got=%b exp=00", {fb_mbus_AVALID, dbus_AREADY});
        end
        nxt();
        #2;
        checks++;
        if ({fb_mbus_BREADY, fb_mbus_AVALID} !== 2'b10) begin
            errs++;
            $display("FAIL abort_idle got=%b exp=10", {fb_mbus_BREADY, fb_mbus_AVALID});
        end
        nxt();
    endtask

    task automatic test_timeout;
        bit fp_bv = 1'b0;
        idle_inputs();
        ibus_AVALID = 1'b1; ibus_AADDR = 32'h500; fb_mbus_AREADY = 1'b1;
        for (int c = 0; c < 17; c++) begin
            if (c == 2)  ibus_AVALID = 1'b0;
            if (c == 11) ibus_BREADY = 1'b1;
            if (c == 12) begin
                ibus_BREADY = 1'b0; fb_mbus_BVALID = 1'b1; fb_mbus_BDATA = 32'h77;
            end
            if (c == 13) begin
                fb_mbus_BVALID = 1'b0; dbus_AVALID = 1'b1; dbus_AADDR = 32'h600;
                dbus_AWMSK = 4'h0; dbus_BREADY = 1'b1;
            end
            if (c == 15) begin
                dbus_AVALID = 1'b0; fb_mbus_BVALID = 1'b1; fb_mbus_BDATA = 32'hCAFEF00D;
            end
            if (c == 16) fb_mbus_BVALID = 1'b0;
            #2;
            if (c >= 2 && c <= 11 && ibus_BVALID_f) fp_bv = 1'b1;
            if (c >= 2 && c <= 9) begin
                checks++;
                if ({ibus_BVALID, fb_mbus_BREADY} !== 2'b00) begin
                    errs++;
                    $display("FAIL tmo_wait_c%0d got=%b exp=00", c, {ibus_BVALID, fb_mbus_BREADY});
                end
            end
            if (c == 10 || c == 11) begin
                checks++;
                if ({ibus_BVALID, ibus_BDATA, ibus_BEXC, fb_mbus_BREADY, dbus_BVALID}
                    !== {1'b1, 32'h0, 2'b11, 1'b0, 1'b0}) begin
                    errs++;
                    $display("FAIL tmo_err_c%0d got=%b/%h/%b/%b/%b exp=1/00000000/11/0/0",
                             c, ibus_BVALID, ibus_BDATA, ibus_BEXC, fb_mbus_BREADY, dbus_BVALID);
                end
            end
            if (c == 12) begin
                checks++;
                if ({ibus_BVALID, fb_mbus_BREADY} !== 2'b01) begin
                    errs++;
                    $display("FAIL tmo_stray_sink got=%b exp=01", {ibus_BVALID, fb_mbus_BREADY});
                end
            end
            if (c == 14) begin
                checks++;
                if ({fb_mbus_AVALID, fb_mbus_AADDR, dbus_AREADY} !== {1'b1, 32'h600, 1'b1}) begin
                    errs++;
                    $display("FAIL tmo_next_req got=%b/%h/%b exp=1/00000600/1",
                             fb_mbus_AVALID, fb_mbus_AADDR, dbus_AREADY);
                end
            end
            if (c == 15) begin
                checks++;
                if ({dbus_BVALID, dbus_BDATA, dbus_BEXC} !== {1'b1, 32'hCAFEF00D, 2'b00}) begin
                    errs++;
                    $display("FAIL tmo_next_resp got=%b/%h/%b exp=1/cafef00d/00",
                             dbus_BVALID, dbus_BDATA, dbus_BEXC);
                end
            end
            nxt();
        end
        checks++;
        if (fp_bv !== 1'b0) begin
            errs++;
            $display("FAIL no_wdog_bvalid got=%b exp=0", fp_bv);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_resp;
        idle_inputs();
        ibus_AVALID = 1'b1; ibus_AADDR = 32'h700; ibus_BREADY = 1'b1;
        dbus_BREADY = 1'b1; fb_mbus_AREADY = 1'b1;
        nxt();                          // REQ, A handshake
        nxt();                          // RESP
        ibus_AVALID = 1'b0;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        fb_mbus_BVALID = 1'b1; fb_mbus_BDATA = 32'h1111;
        #2;
        checks++;
        if ({ibus_BVALID, dbus_BVALID, fb_mbus_BREADY} !== 3'b001) begin
            errs++;
            $display("FAIL rstmid_drop got=%b exp=001", {ibus_BVALID, dbus_BVALID, fb_mbus_BREADY});
        end
        nxt();
        fb_mbus_BVALID = 1'b0; ibus_AVALID = 1'b1; ibus_AADDR = 32'h800;
        nxt();
        #2;
        checks++;
        if ({fb_mbus_AVALID, fb_mbus_AADDR, ibus_AREADY} !== {1'b1, 32'h800, 1'b1}) begin
            errs++;
            $display("FAIL rstmid_regrant got=%b/%h/%b exp=1/00000800/1",
                     fb_mbus_AVALID, fb_mbus_AADDR, ibus_AREADY);
        end
        nxt();
        ibus_AVALID = 1'b0; fb_mbus_BVALID = 1'b1; fb_mbus_BDATA = 32'h2222;
        #2;
        checks++;
        if ({ibus_BVALID, ibus_BDATA} !== {1'b1, 32'h2222}) begin
            errs++;
            $display("FAIL rstmid_resp got=%b/%h exp=1/00002222", ibus_BVALID, ibus_BDATA);
        end
        nxt();
        idle_inputs();
        nxt();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_ibus_read();
        test_back_to_back();
        test_write_stall();
        test_abort();
        test_timeout();
        test_reset_mid_resp();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
